cdc_register_tx_fifo: RTL and testbench

//   Write-side feeder for the cdc_register handshake crossing. It buffers a burst
//   of words in the source clock domain and drains them one at a time into the

---
 rtl/cdc_register_tx_fifo.sv | 101 ++++++++++
 tb/tb_cdc_register_tx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_register_tx_fifo.sv
// ---------------------------------------------------------------------------
// cdc_register_tx_fifo
//
// Write-side feeder for the cdc_register handshake crossing. It buffers a
// burst of producer words in the source clock domain and presents them one
// at a time to the crossing's wr/wr_ready interface. The crossing only takes
// a word every several slow-domain cycles, so this lets the producer run a
// short burst at full rate instead of stalling on every word.
//
// Handshake semantics (both sides): a word moves on a rising clk edge where
// valid and ready are both 1. in_ready and out_wr come straight from
// registered state, so neither depends combinationally on the other side.
// A producer that sees in_ready=0 must hold its word and retry.
//
// Ports
//   clk           source clock (same net as the cdc_register wr_clk)
//   reset         synchronous, active-high; empties the FIFO, clears overflow
//   in_data       producer word
//   in_valid      producer offers in_data this cycle
//   in_ready      FIFO can accept a word this cycle (level != depth)
//   out_data      head word, first-word fall-through (cdc_register wr_data)
//   out_wr        head word valid (cdc_register wr)
//   out_ready     crossing accepts the head word (cdc_register wr_ready)
//   level         number of words stored
//   overflow      sticky: a word was offered while in_ready=0
//   overflow_clr  one-cycle pulse that clears overflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module cdc_register_tx_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [data_width-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [data_width-1:0]   out_data,
    output logic                    out_wr,
    input  logic                    out_ready,
    output logic [$clog2(depth):0]  level,
    output logic                    overflow,
    input  logic                    overflow_clr
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_level = (aw + 1)'(depth);

    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic [aw:0]           level_q;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;

    // Both flags depend only on the registered level.
    assign in_ready = (level_q != full_level);
    assign out_wr   = (level_q != '0);
    assign push     = in_valid & in_ready;
    assign pop      = out_wr & out_ready;

    assign out_data = mem[rd_ptr];
    assign level    = level_q;
    assign overflow = overflow_q;

    // Storage is deliberately not reset; level alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // depth is a power of two, so the pointers wrap by natural rollover.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            // Set has priority so a refused offer in the clear cycle is not lost.
            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdc_register_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_cdc_register_tx_fifo
//
// Directed bench for cdc_register_tx_fifo (data_width=32, depth=8). A
// negedge monitor keeps a reference queue of accepted words and an overflow
// model, checks level/out_wr/in_ready/out_data/overflow every cycle and
// compares each popped word against the queue head. The main initial block
// walks through reset, hold, fill/overflow, full pop, streaming, mid-run
// reset and a slow-acceptor burst that stands in for the crossing.
// ---------------------------------------------------------------------------
module tb_cdc_register_tx_fifo;

    localparam int W = 32;
    localparam int D = 8;

    // clock / reset
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_wr;
    logic          out_ready = 1'b0;
    logic [3:0]    level;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    cdc_register_tx_fifo #(.data_width(W), .depth(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_wr       (out_wr),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    int checks = 0;
    int errors = 0;
    int pop_count = 0;

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic         exp_ovf = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] exp_word;
        if (reset) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            checks++;
            assert (level === 4'(exp_q.size())) else begin
                errors++; $error("FAIL level observed %0d expected %0d", level, exp_q.size());
            end
            checks++;
            assert (out_wr === (exp_q.size() != 0)) else begin
                errors++; $error("FAIL out_wr observed %b expected %b", out_wr, exp_q.size() != 0);
            end
            checks++;
            assert (in_ready === (exp_q.size() != D)) else begin
                errors++; $error("FAIL in_ready observed %b expected %b", in_ready, exp_q.size() != D);
            end
            checks++;
            assert (overflow === exp_ovf) else begin
                errors++; $error("FAIL overflow observed %b expected %b", overflow, exp_ovf);
            end
            if (exp_q.size() != 0) begin
                checks++;
                assert (out_data === exp_q[0]) else begin
                    errors++; $error("FAIL head observed %h expected %h", out_data, exp_q[0]);
                end
            end
            if (in_valid && exp_q.size() == D) begin
                exp_ovf = 1'b1;
            end else if (overflow_clr) begin
                exp_ovf = 1'b0;
            end
            if (out_wr && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL pop_empty observed %h expected no pop", out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    checks++;
                    pop_count++;
                    assert (out_data === exp_word) else begin
                        errors++; $error("FAIL pop_data observed %h expected %h", out_data, exp_word);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++; $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (level != 0 && n < budget) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        check("drain_done", 32'(level), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_out_wr",   32'(out_wr),   32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level",    32'(level),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
    endtask

    initial begin
        int k;
        int n;
        int start_pops;
        logic accepted;

        step();
        do_reset();

        // 1: single word, held
        push_word(32'hA5A5_0001);
        check("t1_out_wr", 32'(out_wr), 32'd1);
        check("t1_data",   out_data,    32'hA5A5_0001);
        check("t1_level",  32'(level),  32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t1_hold", out_data, 32'hA5A5_0001);
        end
        drain(20);

        // 2: fill to full, overflow, clear, set-wins
        for (int i = 0; i < 8; i++) begin
            push_word(32'h10 + 32'(i));
        end
        check("t2_level",    32'(level),    32'd8);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        push_word(32'h18);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_level_hold", 32'(level), 32'd8);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);
        in_valid = 1'b1;
        overflow_clr = 1'b1;
        step();
        in_valid = 1'b0;
        overflow_clr = 1'b0;
        check("t2_set_wins", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;

        // 3: pop from full while offering; no push that cycle
        check("t3_head", out_data, 32'h10);
        in_data = 32'h18;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t3_level",    32'(level),    32'd7);
        check("t3_in_ready", 32'(in_ready), 32'd1);
        check("t3_head2",    out_data,      32'h11);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        drain(20);

        // 4: stream 20 words, out_ready toggling
        start_pops = pop_count;
        k = 0;
        n = 0;
        while ((pop_count - start_pops) < 20 && n < 200) begin
            in_valid  = (k < 20);
            in_data   = 32'h100 + 32'(k);
            out_ready = n[0];
            accepted  = in_valid && in_ready;
            step();
            if (accepted) k++;
            checks++;
            assert (level <= 4'd8) else begin
                errors++; $error("FAIL t4_level_max observed %0d expected <=8", level);
            end
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t4_pops", 32'(pop_count - start_pops), 32'd20);
        check("t4_empty", 32'(level), 32'd0);

        // 5: reset with 5 words held
        for (int i = 0; i < 5; i++) begin
            push_word(32'h200 + 32'(i));
        end
        check("t5_level", 32'(level), 32'd5);
        do_reset();
        push_word(32'h0000_0055);
        check("t5_first", out_data, 32'h0000_0055);
        drain(20);

        // 6: 16-word burst into a slow acceptor
        start_pops = pop_count;
        k = 0;
        n = 0;
        while ((pop_count - start_pops) < 16 && n < 2000) begin
            in_valid  = (k < 16);
            in_data   = 32'($urandom_range(0, 32'h7fff_ffff));
            out_ready = ($urandom_range(0, 7) == 0);
            accepted  = in_valid && in_ready;
            step();
            if (accepted) k++;
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t6_pops", 32'(pop_count - start_pops), 32'd16);
        check("t6_empty", 32'(level), 32'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
